// File: rtl/riscv_uart_pkg.sv
// ============================================================================
// riscv_uart_pkg : shared constants, FSM encoding and helpers for the UART RX.
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

`ifdef RISCV_UARTRX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;
`endif

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_uartrx_fifo.sv
// ============================================================================
// riscv_uartrx_fifo : synchronous FIFO with wrap-bit pointers and a drop pulse.
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_uartrx_fifo
    import riscv_uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int         AW      = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_pop;
    logic             w_wr;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_pop  = pop_i & ~empty_o;
    assign w_wr   = push_i & (~full_o | w_pop);
    assign drop_o = push_i & full_o & ~w_pop;

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_wr)  wptr_q <= wptr_q + PTR_ONE;
            if (w_pop) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/riscv_uartrx.sv
// ============================================================================
// riscv_uartrx : memory-mapped 8N1 UART receiver with receive FIFO.
// Define RISCV_UARTRX_PARITY_EN for 8E1 framing and a parity_err flag.  Rev 1.0
// ============================================================================
`default_nettype none

module riscv_uartrx
    import riscv_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       i_riscv_uartrx_clk,
    input  logic       i_riscv_uartrx_rst_n,
    input  logic       i_riscv_uartrx_rx,
    input  logic       i_riscv_uartrx_rden,
    input  logic       i_riscv_uartrx_clr_err,
    output logic [7:0] o_riscv_uartrx_rdata,
    output logic       o_riscv_uartrx_empty,
    output logic       o_riscv_uartrx_full,
    output logic       o_riscv_uartrx_frame_err,
    output logic       o_riscv_uartrx_overrun,
`ifdef RISCV_UARTRX_PARITY_EN
    output logic       o_riscv_uartrx_parity_err,
`endif
    output logic       o_riscv_uartrx_irq
);

    localparam int               CNT_W     = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta_q;
    logic                      rx_sync_q;
    logic                      rx_prev_q;
    rx_state_e                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      frame_err_q;
    logic                      overrun_q;
    logic                      w_bit_end;
    logic                      w_stop_smp;
    logic                      w_push;
    logic                      w_frame_evt;
    logic                      w_drop;
    logic                      w_err_any;

    always_ff @(posedge i_riscv_uartrx_clk or negedge i_riscv_uartrx_rst_n) begin
        if (!i_riscv_uartrx_rst_n) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_sync_q <= IDLE_LEVEL;
            rx_prev_q <= IDLE_LEVEL;
        end else begin
            rx_meta_q <= i_riscv_uartrx_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign w_bit_end   = (cnt_q == BIT_LAST);
    assign w_stop_smp  = (state_q == ST_STOP) && w_bit_end;
    assign w_frame_evt = w_stop_smp & ~rx_sync_q;

`ifdef RISCV_UARTRX_PARITY_EN
    logic parity_bad_q;
    logic parity_err_q;
    logic w_parity_evt;
    assign w_parity_evt = (state_q == ST_PARITY) && w_bit_end && ((^shift_q) ^ rx_sync_q);
    assign w_push       = w_stop_smp & rx_sync_q & ~parity_bad_q;
`else
    assign w_push       = w_stop_smp & rx_sync_q;
`endif

    always_ff @(posedge i_riscv_uartrx_clk or negedge i_riscv_uartrx_rst_n) begin
        if (!i_riscv_uartrx_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef RISCV_UARTRX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
`ifdef RISCV_UARTRX_PARITY_EN
                        if (bit_idx_q == LAST_IDX) state_q <= ST_PARITY;
`else
                        if (bit_idx_q == LAST_IDX) state_q <= ST_STOP;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`ifdef RISCV_UARTRX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        cnt_q        <= '0;
                        parity_bad_q <= w_parity_evt;
                        state_q      <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    riscv_uartrx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (i_riscv_uartrx_clk),
        .rst_ni  (i_riscv_uartrx_rst_n),
        .push_i  (w_push),
        .pop_i   (i_riscv_uartrx_rden),
        .wdata_i (shift_q),
        .rdata_o (o_riscv_uartrx_rdata),
        .empty_o (o_riscv_uartrx_empty),
        .full_o  (o_riscv_uartrx_full),
        .drop_o  (w_drop)
    );

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge i_riscv_uartrx_clk or negedge i_riscv_uartrx_rst_n) begin
        if (!i_riscv_uartrx_rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RISCV_UARTRX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= w_frame_evt | (frame_err_q & ~i_riscv_uartrx_clr_err);
            overrun_q   <= w_drop      | (overrun_q   & ~i_riscv_uartrx_clr_err);
`ifdef RISCV_UARTRX_PARITY_EN
            parity_err_q <= w_parity_evt | (parity_err_q & ~i_riscv_uartrx_clr_err);
`endif
        end
    end

`ifdef RISCV_UARTRX_PARITY_EN
    assign o_riscv_uartrx_parity_err = parity_err_q;
    assign w_err_any = frame_err_q | overrun_q | parity_err_q;
`else
    assign w_err_any = frame_err_q | overrun_q;
`endif

    assign o_riscv_uartrx_frame_err = frame_err_q;
    assign o_riscv_uartrx_overrun   = overrun_q;
    assign o_riscv_uartrx_irq       = ~o_riscv_uartrx_empty | w_err_any;

endmodule

`default_nettype wire

// File: tb/tb_riscv_uartrx.sv
// ============================================================================
// tb_riscv_uartrx : scoreboard bench for riscv_uartrx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_uartrx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef RISCV_UARTRX_PARITY_EN
    localparam int LATENCY = 171;
`else
    localparam int LATENCY = 155;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rden     = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic       irq;
`ifdef RISCV_UARTRX_PARITY_EN
    logic       parity_err;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];

    riscv_uartrx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_riscv_uartrx_clk       (clk),
        .i_riscv_uartrx_rst_n     (rst_n),
        .i_riscv_uartrx_rx        (rx),
        .i_riscv_uartrx_rden      (rden),
        .i_riscv_uartrx_clr_err   (clr_err),
        .o_riscv_uartrx_rdata     (rdata),
        .o_riscv_uartrx_empty     (empty),
        .o_riscv_uartrx_full      (full),
        .o_riscv_uartrx_frame_err (frame_err),
        .o_riscv_uartrx_overrun   (overrun),
`ifdef RISCV_UARTRX_PARITY_EN
        .o_riscv_uartrx_parity_err(parity_err),
`endif
        .o_riscv_uartrx_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
`ifdef RISCV_UARTRX_PARITY_EN
        rx = ^b;
        repeat (CPB) tick();
`endif
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic pop();
        rden = 1'b1;
        tick();
        rden = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"},     rdata,     32'h00);
        check({tag, "_empty"},     empty,     32'h1);
        check({tag, "_full"},      full,      32'h0);
        check({tag, "_frame_err"}, frame_err, 32'h0);
        check({tag, "_overrun"},   overrun,   32'h0);
        check({tag, "_irq"},       irq,       32'h0);
`ifdef RISCV_UARTRX_PARITY_EN
        check({tag, "_parity_err"}, parity_err, 32'h0);
`endif
    endtask

    // Scoreboard monitor: every accepted pop is matched against the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && rden && !empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rdata);
            end else begin
                check("pop_data", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int         lat;
        logic [7:0] v;

        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Single byte: latency from start edge to empty falling, then drain.
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (empty && lat < 300) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
            end
        join
        check("a5_latency",   lat,       LATENCY);
        check("a5_frame_err", frame_err, 32'h0);
        check("a5_irq",       irq,       32'h1);
        pop();
        check("a5_empty_after_pop", empty, 32'h1);
        check("a5_irq_after_pop",   irq,   32'h0);

        // Start glitch.
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (40) tick();
        check("glitch_empty",     empty,     32'h1);
        check("glitch_frame_err", frame_err, 32'h0);
        check("glitch_overrun",   overrun,   32'h0);
        check("glitch_irq",       irq,       32'h0);

        // Frame error.
        send_frame(8'h3C, 1'b0);
        repeat (5) tick();
        check("ferr_frame_err", frame_err, 32'h1);
        check("ferr_empty",     empty,     32'h1);
        check("ferr_irq",       irq,       32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ferr_cleared", frame_err, 32'h0);
        check("ferr_irq_cleared", irq,   32'h0);

        // Overrun: five bytes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i);
            if (i <= DEPTH) exp_q.push_back(v);
            send_frame(v, 1'b1);
            repeat (4) tick();
        end
        check("ovr_full",    full,    32'h1);
        check("ovr_overrun", overrun, 32'h1);
        check("ovr_irq",     irq,     32'h1);
        repeat (DEPTH) pop();
        check("ovr_empty",   empty,   32'h1);
        check("ovr_sticky",  overrun, 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_cleared", overrun, 32'h0);
        check("ovr_irq_cleared", irq, 32'h0);

        // Full FIFO with a pop on the stop-sample cycle of the next byte.
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i * 16);
            exp_q.push_back(v);
            send_frame(v, 1'b1);
            repeat (4) tick();
        end
        check("fp_full_before", full, 32'h1);
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (LATENCY - 1) tick();
                rden = 1'b1;
                tick();
                rden = 1'b0;
            end
        join
        repeat (2) tick();
        check("fp_overrun", overrun, 32'h0);
        check("fp_full",    full,    32'h1);
        repeat (DEPTH) pop();
        check("fp_empty",   empty,   32'h1);

        // Reset in the middle of a frame while the FIFO holds a byte.
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1);
        repeat (4) tick();
        check("mid_prefill", empty, 32'h0);
        v = 8'hF0;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat ((i == 3) ? CPB / 2 : CPB) tick();
        end
        rst_n = 1'b0;
        exp_q.delete();
        rx = 1'b1;
        #2;
        check_reset_values("midrst");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midrst_after_release", empty, 32'h1);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        repeat (4) tick();
        check("midrst_0f_present", empty, 32'h0);
        pop();
        check("midrst_empty",     empty,     32'h1);
        check("midrst_frame_err", frame_err, 32'h0);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
